// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/ready handshake plus a response-valid
// return path. The fetch unit is the master, instruction memory the slave.
interface instr_fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemRspValid;
  logic [31:0] imemRspData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemRspValid,
    input  imemRspData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemRspValid,
    output imemRspData
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, keeps at most one imem request outstanding, presents
// {pcOut, instructionOut, instrValid} registered, honours stall and redirect,
// and uses a kill flag to drop responses that belong to abandoned requests.
// Optional build macro FETCH_PERF_CNT_EN adds saturating performance counters
// (fetchCount, stallCycles, killCount).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request driven at pc; waiting for imemReady
// S_WAIT  | one request outstanding; waiting for imemRspValid
// S_HOLD  | response captured while IF/ID stalled; waiting for fetchEnable
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetchEnable,
  input  logic               redirectValid,
  input  logic [31:0]        redirectPc,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        pcOut,
  output logic [31:0]        instructionOut,
  output logic               instrValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetchCount,
  output logic [31:0]        stallCycles,
  output logic [15:0]        killCount
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        kill_rst_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic        valid_out_q, valid_out_d;

  // Request is a pure function of registered state, so it never glitches.
  assign imem.imemReq  = (state_q == S_FETCH);
  assign imem.imemAddr = pc_q & ~32'h3;

  assign pcOut          = pc_out_q;
  assign instructionOut = instr_out_q;
  assign instrValid     = valid_out_q;

  // Value of kill loaded by reset: a request accepted at or before the reset
  // edge whose response has not yet returned is still in flight and must be
  // dropped when it arrives.
  always_comb begin
    kill_rst_d = 1'b0;
    if (!imem.imemRspValid) begin
      kill_rst_d = (state_q == S_WAIT) || kill_q;
    end
    if ((state_q == S_FETCH) && imem.imemReady) begin
      kill_rst_d = 1'b1;
    end
  end

  // Next-state, PC, kill and output-register logic; redirect overrides the FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    hold_d      = hold_q;
    pc_out_d    = pc_out_q;
    instr_out_d = instr_out_q;
    valid_out_d = valid_out_q;

    // IF/ID accepting with nothing new to offer: present a bubble, keep pcOut.
    if (fetchEnable) begin
      instr_out_d = NOP_INSTR;
      valid_out_d = 1'b0;
    end

    if (redirectValid) begin
      pc_d        = redirectPc & ~32'h3;
      instr_out_d = NOP_INSTR;
      valid_out_d = 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (imem.imemReady) begin
            // The request just accepted carries the old PC; kill its response.
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            kill_d  = kill_q && !imem.imemRspValid;
            state_d = S_FETCH;
          end
        end
        S_WAIT: begin
          if (imem.imemRspValid) begin
            // The in-flight response arrived with the redirect: drop it here,
            // nothing is left outstanding.
            kill_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          state_d = S_FETCH;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          // A stale response landing before the next request is accepted
          // settles the pending kill without touching the outputs.
          if (imem.imemRspValid && kill_q) begin
            kill_d = 1'b0;
          end
          if (imem.imemReady) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imemRspValid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_FETCH;
            end else if (fetchEnable) begin
              pc_out_d    = pc_q;
              instr_out_d = imem.imemRspData;
              valid_out_d = 1'b1;
              pc_d        = pc_q + 32'd4;
              state_d     = S_FETCH;
            end else begin
              hold_d  = imem.imemRspData;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (fetchEnable) begin
            pc_out_d    = pc_q;
            instr_out_d = hold_q;
            valid_out_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = S_FETCH;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      kill_q      <= kill_rst_d;
      hold_q      <= '0;
      pc_out_q    <= '0;
      instr_out_q <= NOP_INSTR;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      hold_q      <= hold_d;
      pc_out_q    <= pc_out_d;
      instr_out_q <= instr_out_d;
      valid_out_q <= valid_out_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] kill_count_q, kill_count_d;
  logic        deliver_evt;
  logic        drop_evt;

  // Saturating event counters.
  always_comb begin
    deliver_evt = fetchEnable && valid_out_d && !redirectValid;
    drop_evt    = imem.imemRspValid &&
                  (((state_q == S_WAIT) && (kill_q || redirectValid)) ||
                   ((state_q == S_FETCH) && kill_q));

    fetch_count_d  = fetch_count_q;
    stall_cycles_d = stall_cycles_q;
    kill_count_d   = kill_count_q;
    if (deliver_evt && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (!fetchEnable && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (drop_evt && (kill_count_q != '1)) begin
      kill_count_d = kill_count_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
      kill_count_q   <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      stall_cycles_q <= stall_cycles_d;
      kill_count_q   <= kill_count_d;
    end
  end

  assign fetchCount  = fetch_count_q;
  assign stallCycles = stall_cycles_q;
  assign killCount   = kill_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: acts as an in-order instruction memory whose
// word at address A is a fixed function of A, and checks the presented
// instruction stream against program order (PC advances by 4 per delivered
// instruction, jumps to the word-aligned target on redirect).
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchEnable;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] pcOut;
  logic [31:0] instructionOut;
  logic        instrValid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCycles;
  logic [15:0] killCount;
`endif

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetchEnable    (fetchEnable),
    .redirectValid  (redirectValid),
    .redirectPc     (redirectPc),
    .imem           (bus),
    .pcOut          (pcOut),
    .instructionOut (instructionOut),
    .instrValid     (instrValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetchCount     (fetchCount),
    .stallCycles    (stallCycles),
    .killCount      (killCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } rsp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned lat_min     = 0;
  int unsigned lat_max     = 0;
  rsp_t        rsp_q[$];
  logic [31:0] exp_pc      = RESET_PC;
  bit          last_accept;
  logic [31:0] last_accept_addr;
  bit          last_deliver;
  int          deliveries  = 0;
  int          exp_v[5]    = '{0, 1, 0, 1, 0};

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory drives any due response, then the edge, then the
  // program-order model checks what the DUT did at that edge.
  task automatic cycle();
    bit          rsp_now;
    logic        pre_req;
    logic [31:0] pre_addr;
    logic [31:0] pre_pc_out;
    logic [31:0] pre_instr;
    logic        pre_valid;
    rsp_now = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    bus.imemRspValid = rsp_now;
    bus.imemRspData  = rsp_now ? rsp_q[0].data : 32'hDEAD_BEEF;
    pre_req    = bus.imemReq;
    pre_addr   = bus.imemAddr;
    pre_pc_out = pcOut;
    pre_instr  = instructionOut;
    pre_valid  = instrValid;
    @(posedge clk);
    #1;
    cyc++;
    last_accept  = 0;
    last_deliver = 0;
    if (rsp_now) void'(rsp_q.pop_front());
    if (pre_req && bus.imemReady) begin
      last_accept      = 1;
      last_accept_addr = pre_addr;
      check("one_outstanding", rsp_q.size(), 0);
      if (!rst) check("fetch_addr", pre_addr, exp_pc);
      rsp_q.push_back('{data: data_of(pre_addr), due: cyc + $urandom_range(lat_max, lat_min)});
    end
    if (rst) begin
      check("rst_pc_out", pcOut, 32'h0);
      check("rst_instr", instructionOut, NOP);
      check("rst_valid", instrValid, 0);
      exp_pc = RESET_PC;
    end else if (redirectValid) begin
      check("flush_valid", instrValid, 0);
      check("flush_instr", instructionOut, NOP);
      exp_pc = redirectPc & ~32'h3;
    end else if (fetchEnable) begin
      if (instrValid) begin
        check("pc_out", pcOut, exp_pc);
        check("instr", instructionOut, data_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
        last_deliver = 1;
      end else begin
        check("bubble_instr", instructionOut, NOP);
        check("bubble_pc_held", pcOut, pre_pc_out);
      end
    end else begin
      check("stall_pc_held", pcOut, pre_pc_out);
      check("stall_instr_held", instructionOut, pre_instr);
      check("stall_valid_held", instrValid, pre_valid);
    end
  endtask

  task automatic run_until_accept(input int budget, output logic [31:0] addr, output int n_deliv);
    int n = 0;
    addr    = 32'hFFFF_FFFF;
    n_deliv = 0;
    do begin
      cycle();
      n++;
      if (last_deliver) n_deliv++;
    end while (!last_accept && n < budget);
    check("accept_timeout", last_accept, 1);
    if (last_accept) addr = last_accept_addr;
  endtask

  initial begin
    logic [31:0] a;
    int          nd;
    int          n;
    int          base_deliv;

    rst                = 1'b1;
    fetchEnable        = 1'b1;
    redirectValid      = 1'b0;
    redirectPc         = '0;
    bus.imemReady      = 1'b0;
    bus.imemRspValid   = 1'b0;
    bus.imemRspData    = '0;

    // Reset
    cycle();
    cycle();
    rst = 1'b0;
    check("req_after_reset", bus.imemReq, 1);
    check("addr_after_reset", bus.imemAddr, RESET_PC);

    // Zero-wait memory, continuous accept: one instruction every 2 cycles
    bus.imemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t1_valid", instrValid, exp_v[i]);
      check("t1_accept", last_accept, (i % 2 == 0));
      if (last_accept) check("t1_addr", last_accept_addr, i * 2);
    end

    // Response for pc=8 arrives during a 3-cycle stall
    fetchEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_req_low", bus.imemReq, 0);
      check("t2_valid_held", instrValid, 0);
      check("t2_pc_held", pcOut, 32'h4);
    end
    fetchEnable = 1'b1;
    lat_min = 2;
    lat_max = 2;
    cycle();
    check("t2_pc_out", pcOut, 32'h8);
    check("t2_instr", instructionOut, 32'h0050_0093);
    check("t2_valid", instrValid, 1);
    cycle();
    check("t2_next_accept", last_accept, 1);
    check("t2_next_addr", last_accept_addr, 32'hC);

    // Redirect while waiting: in-flight response must be dropped
    redirectValid = 1'b1;
    redirectPc    = 32'h100;
    cycle();
    redirectValid = 1'b0;
    lat_min = 0;
    lat_max = 0;
    run_until_accept(20, a, nd);
    check("t3_addr", a, 32'h100);
    check("t3_no_valid", nd, 0);

    // Unaligned target, redirect coinciding with the response
    redirectValid = 1'b1;
    redirectPc    = 32'h203;
    cycle();
    redirectValid = 1'b0;
    run_until_accept(20, a, nd);
    check("t4_addr", a, 32'h200);
    check("t4_no_valid", nd, 0);

    // PC wrap from 0xFFFF_FFFC to 0
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFFC;
    cycle();
    redirectValid = 1'b0;
    run_until_accept(20, a, nd);
    check("t5_top_addr", a, 32'hFFFF_FFFC);
    run_until_accept(20, a, nd);
    check("t5_wrap_addr", a, 32'h0);
    check("t5_deliv", nd, 1);
    lat_min = 1;
    lat_max = 1;
    run_until_accept(20, a, nd);
    check("t5_addr4", a, 32'h4);

    // Reset while waiting; the late response lands just after reset
    rst           = 1'b1;
    bus.imemReady = 1'b0;
    cycle();
    rst           = 1'b0;
    bus.imemReady = 1'b1;
    lat_min = 0;
    lat_max = 0;
    run_until_accept(20, a, nd);
    check("t6_first_addr", a, RESET_PC);
    check("t6_no_valid", nd, 0);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_deliver && n < 10);
    check("t6_deliver_seen", last_deliver, 1);
    check("t6_pc_out", pcOut, RESET_PC);
    check("t6_instr", instructionOut, data_of(RESET_PC));

    // Randomized traffic against the program-order model
    lat_min = 0;
    lat_max = 3;
    base_deliv = deliveries;
    for (int i = 0; i < 3000; i++) begin
      fetchEnable   = ($urandom_range(9, 0) < 7);
      bus.imemReady = ($urandom_range(3, 0) != 0);
      redirectValid = ($urandom_range(24, 0) == 0);
      if ($urandom_range(3, 0) == 0)
        redirectPc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else
        redirectPc = $urandom;
      cycle();
    end
    redirectValid = 1'b0;
    check("rand_progress", (deliveries - base_deliv) > 150, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
